// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU $2006/$2007 data port.
// Address width, palette base, increments, register indices, FSM states.
package ppu_pkg;

    localparam int ADDR_W = 14;

    localparam logic [13:0] PAL_BASE = 14'h3F00;
    localparam logic [13:0] INC1     = 14'd1;
    localparam logic [13:0] INC32    = 14'd32;

    // Clears v[12]: palette reads fetch the nametable byte underneath.
    localparam logic [13:0] NT_MASK  = 14'h2FFF;

    localparam logic [2:0] REG_PPUADDR = 3'd6;
    localparam logic [2:0] REG_PPUDATA = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT
    } ppu_data_state_t;

endpackage

// File: rtl/ppu_addr_latch.sv
// PPU address latch: owns v, t and the write toggle w.
// Ports: addr_wr/wdata ($2006 write), status_read (clears w), inc/inc32
// (advance v), busy (defer v loads until inc), v (current address).
module ppu_addr_latch
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              addr_wr,
    input  logic [7:0]        wdata,
    input  logic              status_read,
    input  logic              inc,
    input  logic              inc32,
    input  logic              busy,
    output logic [ADDR_W-1:0] v
);

    logic [13:0] v_q, v_d;
    logic [13:0] t_q, t_d;
    logic        w_q, w_d;
    logic        pend_q, pend_d;
    logic [13:0] pend_v_q, pend_v_d;
    logic [13:0] t_new;
    logic [13:0] step;

    assign v     = v_q;
    assign step  = inc32 ? INC32 : INC1;
    assign t_new = w_q ? {t_q[13:8], wdata}
                       : {wdata[5:0], t_q[7:0]};

    always_comb begin
        v_d      = v_q;
        t_d      = t_q;
        w_d      = w_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;

        // A load parked during a transaction replaces the increment.
        if (inc) begin
            v_d    = pend_q ? pend_v_q : v_q + step;
            pend_d = 1'b0;
        end

        if (addr_wr) begin
            t_d = t_new;
            w_d = ~w_q;
            if (w_q) begin
                if (busy && !inc) begin
                    pend_d   = 1'b1;
                    pend_v_d = t_new;
                end else begin
                    v_d    = t_new;
                    pend_d = 1'b0;
                end
            end
        end

        // Applied after the $2006 write so w always ends cleared.
        if (status_read) begin
            w_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q      <= '0;
            t_q      <= '0;
            w_q      <= 1'b0;
            pend_q   <= 1'b0;
            pend_v_q <= '0;
        end else begin
            v_q      <= v_d;
            t_q      <= t_d;
            w_q      <= w_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

endmodule

// File: rtl/ppu_data_port.sv
// PPU $2006/$2007 engine: read buffer, palette port, VRAM req/ack FSM.
// Ports: CPU reg bus (reg_sel/cpu_*), status_read, inc32, busy,
// VRAM bus (vram_*), palette RAM port (pal_*).
// Optional macro PPU_DATA_OPEN_BUS_EN adds an open-bus latch.
module ppu_data_port
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        reg_sel,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_write,
    input  logic              cpu_read,
    output logic [7:0]        cpu_rdata,
    input  logic              status_read,
    input  logic              inc32,
    output logic              busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_req,
    output logic              vram_we,
    output logic [7:0]        vram_wdata,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    output logic [4:0]        pal_addr,
    output logic [7:0]        pal_wdata,
    output logic              pal_write,
    input  logic [7:0]        pal_rdata
);

    ppu_data_state_t state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        pal_write_q, pal_write_d;
    logic [7:0]  pal_wdata_q, pal_wdata_d;
    logic [7:0]  rd_buf_q, rd_buf_d;
    logic [13:0] v;
    logic        is_pal;
    logic        data_wr;
    logic        data_rd;
    logic        addr_wr;
    logic        inc;
    logic [7:0]  open_bus;
    logic        unused_pal_hi;

    assign data_wr = cpu_write && (reg_sel == REG_PPUDATA);
    assign data_rd = cpu_read && (reg_sel == REG_PPUDATA);
    assign addr_wr = cpu_write && (reg_sel == REG_PPUADDR);
    assign is_pal  = (v >= PAL_BASE);
    assign busy    = (state_q != IDLE);
    assign inc     = pal_write_q || (busy && vram_ack);

    assign unused_pal_hi = ^pal_rdata[7:6];

    ppu_addr_latch u_addr (
        .clk         (clk),
        .reset       (reset),
        .addr_wr     (addr_wr),
        .wdata       (cpu_wdata),
        .status_read (status_read),
        .inc         (inc),
        .inc32       (inc32),
        .busy        (busy),
        .v           (v)
    );

`ifdef PPU_DATA_OPEN_BUS_EN
    logic [7:0] ob_q, ob_d;

    always_comb begin
        ob_d = ob_q;
        if (cpu_write) begin
            ob_d = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ob_q <= '0;
        end else begin
            ob_q <= ob_d;
        end
    end

    assign open_bus = ob_q;
`else
    assign open_bus = 8'h00;
`endif

    assign vram_addr  = (state_q == RD_WAIT && is_pal) ? (v & NT_MASK) : v;
    assign vram_req   = req_q;
    assign vram_we    = we_q;
    assign vram_wdata = wdata_q;
    assign pal_addr   = v[4:0];
    assign pal_wdata  = pal_wdata_q;
    assign pal_write  = pal_write_q;

    // Palette reads bypass the buffer only when a read can start.
    always_comb begin
        cpu_rdata = open_bus;
        if (reg_sel == REG_PPUDATA) begin
            if (!busy && is_pal) begin
                cpu_rdata = {open_bus[7:6], pal_rdata[5:0]};
            end else begin
                cpu_rdata = rd_buf_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        pal_write_d = 1'b0;
        pal_wdata_d = pal_wdata_q;
        rd_buf_d    = rd_buf_q;
        unique case (state_q)
            IDLE: begin
                if (data_wr) begin
                    if (is_pal) begin
                        pal_write_d = 1'b1;
                        pal_wdata_d = cpu_wdata;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        wdata_d = cpu_wdata;
                        state_d = WR_WAIT;
                    end
                end else if (data_rd) begin
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    state_d = RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (vram_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (vram_ack) begin
                    req_d    = 1'b0;
                    rd_buf_d = vram_rdata;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            pal_write_q <= 1'b0;
            pal_wdata_q <= '0;
            rd_buf_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            pal_write_q <= pal_write_d;
            pal_wdata_q <= pal_wdata_d;
            rd_buf_q    <= rd_buf_d;
        end
    end

endmodule

// File: tb/tb_ppu_data_port.sv
// Self-checking bench for ppu_data_port.
// VRAM/palette environment plus an address/buffer reference model.
module tb_ppu_data_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  reg_sel;
    logic [7:0]  cpu_wdata;
    logic        cpu_write;
    logic        cpu_read;
    logic [7:0]  cpu_rdata;
    logic        status_read;
    logic        inc32;
    logic        busy;
    logic [13:0] vram_addr;
    logic        vram_req;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic        vram_ack;
    logic [7:0]  vram_rdata;
    logic [4:0]  pal_addr;
    logic [7:0]  pal_wdata;
    logic        pal_write;
    logic [7:0]  pal_rdata;

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    logic [7:0] env_vram   [0:16383];
    logic [7:0] model_vram [0:16383];
    logic [7:0] env_pal    [0:31];
    logic [7:0] model_pal  [0:31];

    logic [13:0] m_v;
    logic [7:0]  m_buf;
    logic        m_inc32;

    int ack_lat  = 2;
    bit ack_hold = 0;
    int lat_cnt  = 0;
    bit req_seen = 0;
    int n_req    = 0;

    ppu_data_port dut (
        .clk         (clk),
        .reset       (reset),
        .reg_sel     (reg_sel),
        .cpu_wdata   (cpu_wdata),
        .cpu_write   (cpu_write),
        .cpu_read    (cpu_read),
        .cpu_rdata   (cpu_rdata),
        .status_read (status_read),
        .inc32       (inc32),
        .busy        (busy),
        .vram_addr   (vram_addr),
        .vram_req    (vram_req),
        .vram_we     (vram_we),
        .vram_wdata  (vram_wdata),
        .vram_ack    (vram_ack),
        .vram_rdata  (vram_rdata),
        .pal_addr    (pal_addr),
        .pal_wdata   (pal_wdata),
        .pal_write   (pal_write),
        .pal_rdata   (pal_rdata)
    );

    assign pal_rdata = env_pal[pal_addr];

    always @(posedge clk) begin
        if (pal_write) env_pal[pal_addr] <= pal_wdata;
    end

    // VRAM responder: ack after ack_lat cycles of request.
    always @(negedge clk) begin
        if (vram_req && !req_seen) begin
            n_req++;
            req_seen = 1;
        end
        if (!vram_req) req_seen = 0;
        if (vram_ack) begin
            vram_ack = 0;
        end else if (vram_req && !ack_hold && !reset) begin
            if (lat_cnt >= ack_lat) begin
                vram_ack = 1;
                lat_cnt  = 0;
                if (vram_we) env_vram[vram_addr] = vram_wdata;
                else vram_rdata = env_vram[vram_addr];
            end else begin
                lat_cnt++;
            end
        end else if (!vram_req) begin
            lat_cnt = 0;
        end
    end

    function automatic logic [13:0] next_v(input logic [13:0] a);
        int n;
        n = (int'(a) + (m_inc32 ? 32 : 1)) % 16384;
        return n[13:0];
    endfunction

    function automatic bit in_pal(input logic [13:0] a);
        return int'(a) >= 'h3F00;
    endfunction

    task automatic m_write(input logic [7:0] d);
        if (in_pal(m_v)) model_pal[m_v[4:0]] = d;
        else model_vram[m_v] = d;
        m_v = next_v(m_v);
    endtask

    task automatic m_read(output logic [7:0] e);
        logic [13:0] a;
        if (in_pal(m_v)) e = {2'b00, model_pal[m_v[4:0]][5:0]};
        else e = m_buf;
        a = in_pal(m_v) ? m_v - 14'h1000 : m_v;
        m_buf = model_vram[a];
        m_v = next_v(m_v);
    endtask

    task automatic poke(input logic [13:0] a, input logic [7:0] d);
        env_vram[a] = d;
        model_vram[a] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [2:0] r, input logic [7:0] d);
        reg_sel = r;
        cpu_wdata = d;
        cpu_write = 1;
        tick();
        cpu_write = 0;
    endtask

    task automatic cpu_rd(input logic [2:0] r, output logic [7:0] d);
        reg_sel = r;
        cpu_read = 1;
        #1;
        d = cpu_rdata;
        tick();
        cpu_read = 0;
    endtask

    task automatic pulse_status();
        status_read = 1;
        tick();
        status_read = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        while (busy && n < 100) begin
            tick();
            n++;
        end
        ncmp++;
        if (busy) begin
            nerr++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, need 0", busy, n);
        end
    endtask

    task automatic set_v(input logic [13:0] a);
        pulse_status();
        cpu_wr(3'd6, {2'b00, a[13:8]});
        cpu_wr(3'd6, a[7:0]);
        m_v = a;
    endtask

    task automatic do_write(input logic [7:0] d);
        cpu_wr(3'd7, d);
        m_write(d);
        wait_idle();
    endtask

    task automatic do_read(input string nm);
        logic [7:0] got, e;
        cpu_rd(3'd7, got);
        m_read(e);
        ncmp++;
        if (got !== e) begin
            nerr++;
            $display("FAIL %s: cpu_rdata=%02h need %02h", nm, got, e);
        end
        wait_idle();
    endtask

    task automatic chk_v(input string nm);
        ncmp++;
        if (vram_addr !== m_v) begin
            nerr++;
            $display("FAIL %s: vram_addr=%04h need %04h", nm, vram_addr, m_v);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        tick();
        m_v = '0;
        m_buf = '0;
        ncmp++;
        if ({vram_req, vram_we, busy, pal_write, vram_wdata, pal_wdata,
             vram_addr} !== 34'd0) begin
            nerr++;
            $display("FAIL reset: req=%0b we=%0b busy=%0b pw=%0b wd=%02h pd=%02h a=%04h need all 0",
                     vram_req, vram_we, busy, pal_write, vram_wdata, pal_wdata, vram_addr);
        end
    endtask

    task automatic test_pal_write();
        int r0;
        r0 = n_req;
        inc32 = 0;
        m_inc32 = 0;
        set_v(14'h3F10);
        cpu_wr(3'd7, 8'h2A);
        m_write(8'h2A);
        ncmp++;
        if ({pal_write, pal_addr, pal_wdata} !== {1'b1, 5'h10, 8'h2A}) begin
            nerr++;
            $display("FAIL pal_write: pw=%0b pa=%02h pd=%02h need 1/10/2A",
                     pal_write, pal_addr, pal_wdata);
        end
        tick();
        ncmp++;
        if (pal_write !== 1'b0) begin
            nerr++;
            $display("FAIL pal_pulse: pal_write=%0b need 0", pal_write);
        end
        chk_v("pal_write_v");
        ncmp++;
        if (n_req != r0) begin
            nerr++;
            $display("FAIL pal_no_req: reqs=%0d need %0d", n_req, r0);
        end
    endtask

    task automatic test_vram_read();
        ack_lat = 2;
        poke(14'h2000, 8'h55);
        poke(14'h2001, 8'h66);
        set_v(14'h2000);
        do_read("vram_read1");
        do_read("vram_read2");
        chk_v("vram_read_v");
    endtask

    task automatic test_pal_read();
        env_pal[1] = 8'h3C;
        model_pal[1] = 8'h3C;
        poke(14'h2F01, 8'h77);
        set_v(14'h3F01);
        begin
            logic [7:0] got, e;
            cpu_rd(3'd7, got);
            m_read(e);
            ncmp++;
            if (got !== e) begin
                nerr++;
                $display("FAIL pal_read: cpu_rdata=%02h need %02h", got, e);
            end
        end
        ncmp++;
        if ({vram_req, vram_we, vram_addr} !== {1'b1, 1'b0, 14'h2F01}) begin
            nerr++;
            $display("FAIL pal_read_nt: req=%0b we=%0b addr=%04h need 1/0/2F01",
                     vram_req, vram_we, vram_addr);
        end
        wait_idle();
        set_v(14'h0000);
        do_read("pal_read_buf");
    endtask

    task automatic test_wrap();
        inc32 = 1;
        m_inc32 = 1;
        set_v(14'h3FF0);
        do_write(8'($urandom));
        chk_v("wrap_inc32");
        inc32 = 0;
        m_inc32 = 0;
        set_v(14'h3FFF);
        do_write(8'($urandom));
        chk_v("wrap_inc1");
    endtask

    task automatic test_toggle();
        pulse_status();
        cpu_wr(3'd6, 8'h3F);
        pulse_status();
        cpu_wr(3'd6, 8'h12);
        cpu_wr(3'd6, 8'h34);
        m_v = 14'h1234;
        chk_v("toggle_status");
        status_read = 1;
        cpu_wr(3'd6, 8'h3F);
        status_read = 0;
        cpu_wr(3'd6, 8'h21);
        cpu_wr(3'd6, 8'h43);
        m_v = 14'h2143;
        chk_v("toggle_coincident");
    endtask

    task automatic test_back_to_back();
        int r0;
        logic [7:0] got;
        set_v(14'h0100);
        ack_hold = 1;
        r0 = n_req;
        cpu_wr(3'd7, 8'hAA);
        cpu_wr(3'd7, 8'hBB);
        repeat (3) tick();
        ncmp++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL busy_hold: busy=%0b need 1", busy);
        end
        cpu_rd(3'd7, got);
        ncmp++;
        if (got !== m_buf) begin
            nerr++;
            $display("FAIL busy_read: cpu_rdata=%02h need %02h", got, m_buf);
        end
        ack_hold = 0;
        wait_idle();
        m_write(8'hAA);
        ncmp++;
        if (n_req != r0 + 1) begin
            nerr++;
            $display("FAIL busy_reqs: reqs=%0d need %0d", n_req - r0, 1);
        end
        ncmp++;
        if (env_vram[14'h0100] !== model_vram[14'h0100]) begin
            nerr++;
            $display("FAIL busy_data: vram=%02h need %02h",
                     env_vram[14'h0100], model_vram[14'h0100]);
        end
        chk_v("busy_v");

        // $2006 reload while busy takes effect at ack, not the increment.
        ack_hold = 1;
        cpu_wr(3'd7, 8'h5A);
        model_vram[m_v] = 8'h5A;
        cpu_wr(3'd6, 8'h05);
        cpu_wr(3'd6, 8'h00);
        tick();
        chk_v("defer_hold");
        ack_hold = 0;
        wait_idle();
        m_v = 14'h0500;
        chk_v("defer_apply");
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        ack_hold = 1;
        cpu_wr(3'd7, 8'hCC);
        tick();
        reset = 1;
        tick();
        ncmp++;
        if ({vram_req, busy} !== 2'b00) begin
            nerr++;
            $display("FAIL reset_mid: req=%0b busy=%0b need 0/0", vram_req, busy);
        end
        reset = 0;
        ack_hold = 0;
        m_v = '0;
        m_buf = '0;
        tick();
        chk_v("reset_mid_v");
        poke(14'h0000, 8'h99);
        do_read("reset_mid_buf");
        cpu_rd(3'd3, got);
        ncmp++;
        if (got !== 8'h00) begin
            nerr++;
            $display("FAIL unused_reg: cpu_rdata=%02h need 00", got);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int i = 0; i < 80; i++) begin
            ack_lat = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0: begin
                    if ($urandom_range(0, 1) == 1)
                        set_v(14'h3F00 | 14'($urandom_range(0, 255)));
                    else
                        set_v(14'($urandom));
                end
                1: do_write(8'($urandom));
                2: do_read("rand_read");
                default: begin
                    m_inc32 = 1'($urandom);
                    inc32 = m_inc32;
                    tick();
                end
            endcase
            chk_v("rand_v");
        end
        bad = 0;
        for (int k = 0; k < 32; k++)
            if (env_pal[k] !== model_pal[k]) bad++;
        ncmp++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL rand_palette: %0d entries differ, need 0", bad);
        end
        bad = 0;
        for (int k = 0; k < 16384; k++)
            if (env_vram[k] !== model_vram[k]) bad++;
        ncmp++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL rand_vram: %0d bytes differ, need 0", bad);
        end
    endtask

    initial begin
        reset = 1;
        reg_sel = '0;
        cpu_wdata = '0;
        cpu_write = 0;
        cpu_read = 0;
        status_read = 0;
        inc32 = 0;
        m_inc32 = 0;
        vram_ack = 0;
        vram_rdata = '0;
        for (int k = 0; k < 16384; k++) begin
            env_vram[k] = 8'($urandom);
            model_vram[k] = env_vram[k];
        end
        for (int k = 0; k < 32; k++) begin
            env_pal[k] = 8'($urandom);
            model_pal[k] = env_pal[k];
        end
        test_reset();
        test_pal_write();
        test_vram_read();
        test_pal_read();
        test_wrap();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/ppu_data_port.md
Name: ppu_data_port

Overview:
- CPU-facing PPUADDR ($2006) / PPUDATA ($2007) engine of the PPU.
- Owns the 14-bit VRAM address `v`, temp address `t` and write toggle `w`.
- Drives the palette RAM write/read port (addr/wdata/write, rdata) and the external VRAM bus via a req/ack handshake.
- Implements the PPUDATA read buffer, with palette reads bypassing the buffer, and the +1/+32 address increment.

Parameters:
- ADDR_W, 14, VRAM address width (wrap modulus 2^ADDR_W).
- PAL_BASE, 14'h3F00, first palette-mapped address; addresses ≥ PAL_BASE route to palette.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- reg_sel  in  3  CPU register index (addr[2:0])
- cpu_wdata  in  8  CPU write data
- cpu_write  in  1  one-cycle write strobe
- cpu_read  in  1  one-cycle read strobe
- cpu_rdata  out  8  read data, valid in cycle of cpu_read when reg_sel==7
- status_read  in  1  pulse on $2002 read; clears w
- inc32  in  1  PPUCTRL bit2; 1 → increment 32, else 1
- busy  out  1  VRAM transaction outstanding
- vram_addr  out  14  current v
- vram_req  out  1  VRAM access request, held until ack
- vram_we  out  1  1=write, qualifies vram_req
- vram_wdata  out  8  VRAM write data
- vram_ack  in  1  access done; vram_rdata valid this cycle for reads
- vram_rdata  in  8  VRAM read data
- pal_addr  out  5  palette index (v[4:0])
- pal_wdata  out  8  palette write data
- pal_write  out  1  palette write pulse
- pal_rdata  in  8  palette read data (combinational from palette RAM)

Behaviour:
- Reset values:
  - v, t, w = 0; read buffer = 0; state = IDLE.
  - vram_req, vram_we, pal_write, busy = 0; vram_wdata, pal_wdata = 0.
- Registers:
  - vram_addr = v.
  - pal_addr = v[4:0] (mirror folding is done in palette RAM).
- $2006 write:
  - w==0: t[13:8] ← wdata[5:0], w ← 1.
  - w==1: t[7:0] ← wdata, v ← t_new (same cycle; v visible N+1), w ← 0.
- status_read pulse: w ← 0. If it coincides with a $2006 write, the write is applied first and w still ends at 0.
- Increment: v ← (v + (inc32 ? 32 : 1)) mod 2^14; 3FFF+1 → 0000.
- States: IDLE, WR_WAIT, RD_WAIT.
- $2007 write in IDLE, v ≥ PAL_BASE:
  - Cycle N+1: pal_write=1 for exactly one cycle, pal_wdata=cpu_wdata; v increments.
  - No VRAM access; stays IDLE.
- $2007 write in IDLE, v < PAL_BASE:
  - vram_req=1, vram_we=1, vram_wdata latched; → WR_WAIT.
  - On vram_ack: req drops next cycle, v increments, → IDLE.
- $2007 read in IDLE:
  - cpu_rdata same cycle = (v ≥ PAL_BASE) ? {2'b00, pal_rdata[5:0]} : buffer.
  - Then vram_req=1, vram_we=0, addr = v with bit 12 cleared if v ≥ PAL_BASE (nametable underneath); → RD_WAIT.
  - On ack: buffer ← vram_rdata, v increments, → IDLE.
- busy = (state != IDLE).
- $2007 access while busy:
  - Ignored: no state, v or buffer change; reads return the current buffer.
  - $2006 writes while busy are still accepted, but any v update they produce is deferred until the ack cycle and overrides the increment.
- Ack in the same cycle as req assertion is not possible; ack while IDLE is ignored.
- Reset mid-transaction: immediate return to IDLE, req drops next edge, buffer cleared.
- Other reg_sel values: ignored; cpu_rdata = 0.

Optional Feature:
- Macro: PPU_DATA_OPEN_BUS_EN.
- Defined:
  - An 8-bit open-bus latch is updated on every cpu_write (any reg_sel).
  - Palette reads return {openbus[7:6], pal_rdata[5:0]}; unused reg_sel reads return openbus.
  - Latch resets to 0.
- Undefined: upper bits 2'b00; unused reads 0.

Decomposition:
- Package ppu_pkg:
  - PAL_BASE, INC1 = 14'd1, INC32 = 14'd32.
  - REG_PPUADDR = 3'd6, REG_PPUDATA = 3'd7.
  - typedef enum ppu_data_state_t {IDLE, WR_WAIT, RD_WAIT}.
- One sub-module, ppu_addr_latch: t/v/w registers, $2006 sequencing, increment and deferred-override logic. The FSM and buffer stay in the top.

Test Plan:
- Write $2006=3F, $2006=10, $2007=2A with inc32=0 → pal_write one cycle with pal_addr=10, pal_wdata=2A; v=3F11; vram_req never asserts.
- Set v=2000, VRAM[2000]=55, VRAM[2001]=66; read $2007 twice with ack after 2 cycles → 1st cpu_rdata=00, 2nd=55; v=2002.
- Set v=3F01, pal_rdata=3C, VRAM[2F01]=77; read $2007 → cpu_rdata=3C immediately; vram_addr=2F01 during req; buffer=77 after ack.
- inc32=1, v=3FF0; write $2007 → v wraps to 0010. Also set v=3FFF, inc32=0; write → v=0000.
- $2006 first write (w=1), status_read pulse, then $2006=12, $2006=34 → v=1234.
- Issue VRAM write with ack held off, send second $2007 write while busy → ignored; only one req/ack; v increments once. Assert reset in WR_WAIT → req=0, state IDLE next cycle.
